mips_control_unit: RTL

- Multi-cycle FSM that drives every control signal of the MIPS datapath: write enables, mux selects and ALU op.
- Consumes opcode, funct and ALU status (zero, overflow) fed back from the datapath.
- Implements the subset: add, sub, and, jr, addi, lw, sw, beq, bne, j, plus invalid-opcode and overflow exceptions.

---
 rtl/mips_control_unit.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mips_control_unit.sv
// rtl/mips_control_unit.sv - multi-cycle MIPS control FSM
//
// Purpose: Moore-style control unit that sequences the multi-cycle MIPS
// datapath. It supports add/sub/and/jr, addi, lw/sw, beq/bne and j, and it
// takes an exception on an invalid opcode/funct or on signed overflow.
//
// Ports:
//   clock_i, reset_i        clock (rising edge), async active-high reset
//   opcode_i, funct_i       IR[31:26], IR[5:0]
//   zero_i, overflow_i      ALU status fed back from the datapath
//   pc_write_o ... epc_write_o   write enables / strobes
//   iord_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
//   alu_op_o, pc_source_o   datapath mux selects and ALU operation
module mips_control_unit #(
   parameter int unsigned MEM_WAIT    = 1,
   parameter logic [2:0]  SP_INIT_SEL = 3'd6
) (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic [5:0] opcode_i,
   input  logic [5:0] funct_i,
   input  logic       zero_i,
   input  logic       overflow_i,
   output logic       pc_write_o,
   output logic       pc_write_cond_o,
   output logic       branch_ne_o,
   output logic       mem_write_o,
   output logic       ir_write_o,
   output logic       reg_write_o,
   output logic       ab_write_o,
   output logic       alu_out_write_o,
   output logic       epc_write_o,
   output logic [2:0] iord_o,
   output logic [1:0] reg_dst_o,
   output logic [2:0] mem_to_reg_o,
   output logic       alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [2:0] alu_op_o,
   output logic [1:0] pc_source_o
);

   typedef enum logic [4:0] {
      S_RESET     = 5'd0,
      S_FETCH     = 5'd1,
      S_DECODE    = 5'd2,
      S_R_EXEC    = 5'd3,
      S_R_WB      = 5'd4,
      S_ADDI_EXEC = 5'd5,
      S_ADDI_WB   = 5'd6,
      S_MEM_ADDR  = 5'd7,
      S_LW_READ   = 5'd8,
      S_LW_WB     = 5'd9,
      S_SW_WRITE  = 5'd10,
      S_BRANCH    = 5'd11,
      S_JUMP      = 5'd12,
      S_JR        = 5'd13,
      S_EXC_SAVE  = 5'd14,
      S_EXC_READ  = 5'd15,
      S_EXC_LOAD  = 5'd16
   } state_t;

   localparam logic [1:0] WAIT_LOAD = 2'(MEM_WAIT);

   state_t     state_q, state_d;
   logic [1:0] wait_q, wait_d;
   logic       cause_q, cause_d;   // 0: invalid opcode/funct, 1: overflow
   logic       wait_done;

   // Down-counter: last cycle of a wait state is when it reaches zero.
   assign wait_done = (wait_q == 2'd0);

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= S_RESET;
         wait_q  <= 2'd0;
         cause_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         cause_q <= cause_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      // Reload unless we stay in a wait state, so every entry starts fresh.
      wait_d          = WAIT_LOAD;
      cause_d         = cause_q;
      pc_write_o      = 1'b0;
      pc_write_cond_o = 1'b0;
      branch_ne_o     = 1'b0;
      mem_write_o     = 1'b0;
      ir_write_o      = 1'b0;
      reg_write_o     = 1'b0;
      ab_write_o      = 1'b0;
      alu_out_write_o = 1'b0;
      epc_write_o     = 1'b0;
      iord_o          = 3'd0;
      reg_dst_o       = 2'd0;
      mem_to_reg_o    = 3'd0;
      alu_src_a_o     = 1'b0;
      alu_src_b_o     = 2'd0;
      alu_op_o        = 3'd0;
      pc_source_o     = 2'd0;

      // Outputs are forced low while reset is held, even mid-state.
      if (!reset_i) begin
         case (state_q)
            S_RESET: begin
               reg_write_o  = 1'b1;
               reg_dst_o    = 2'd2;
               mem_to_reg_o = SP_INIT_SEL;
               state_d      = S_FETCH;
            end
            S_FETCH: begin
               iord_o      = 3'd0;
               alu_src_a_o = 1'b0;
               alu_src_b_o = 2'd1;
               alu_op_o    = 3'd1;
               if (wait_done) begin
                  ir_write_o  = 1'b1;
                  pc_write_o  = 1'b1;
                  pc_source_o = 2'd0;
                  state_d     = S_DECODE;
               end else begin
                  wait_d = wait_q - 2'd1;
               end
            end
            S_DECODE: begin
               ab_write_o      = 1'b1;
               alu_out_write_o = 1'b1;
               alu_src_a_o     = 1'b0;
               alu_src_b_o     = 2'd3;
               alu_op_o        = 3'd1;
               case (opcode_i)
                  6'h00: begin
                     case (funct_i)
                        6'h20, 6'h22, 6'h24: state_d = S_R_EXEC;
                        6'h08:               state_d = S_JR;
                        default: begin
                           state_d = S_EXC_SAVE;
                           cause_d = 1'b0;
                        end
                     endcase
                  end
                  6'h08:        state_d = S_ADDI_EXEC;
                  6'h23, 6'h2B: state_d = S_MEM_ADDR;
                  6'h04, 6'h05: state_d = S_BRANCH;
                  6'h02:        state_d = S_JUMP;
                  default: begin
                     state_d = S_EXC_SAVE;
                     cause_d = 1'b0;
                  end
               endcase
            end
            S_R_EXEC: begin
               alu_src_a_o     = 1'b1;
               alu_src_b_o     = 2'd0;
               alu_out_write_o = 1'b1;
               case (funct_i)
                  6'h22:   alu_op_o = 3'd2;
                  6'h24:   alu_op_o = 3'd3;
                  default: alu_op_o = 3'd1;
               endcase
               // AND cannot overflow; the flag is meaningless for it.
               if (funct_i != 6'h24 && overflow_i) begin
                  state_d = S_EXC_SAVE;
                  cause_d = 1'b1;
               end else begin
                  state_d = S_R_WB;
               end
            end
            S_R_WB: begin
               reg_write_o  = 1'b1;
               reg_dst_o    = 2'd1;
               mem_to_reg_o = 3'd0;
               state_d      = S_FETCH;
            end
            S_ADDI_EXEC: begin
               alu_src_a_o     = 1'b1;
               alu_src_b_o     = 2'd2;
               alu_op_o        = 3'd1;
               alu_out_write_o = 1'b1;
               if (overflow_i) begin
                  state_d = S_EXC_SAVE;
                  cause_d = 1'b1;
               end else begin
                  state_d = S_ADDI_WB;
               end
            end
            S_ADDI_WB: begin
               reg_write_o  = 1'b1;
               reg_dst_o    = 2'd0;
               mem_to_reg_o = 3'd0;
               state_d      = S_FETCH;
            end
            S_MEM_ADDR: begin
               alu_src_a_o     = 1'b1;
               alu_src_b_o     = 2'd2;
               alu_op_o        = 3'd1;
               alu_out_write_o = 1'b1;
               state_d         = (opcode_i == 6'h2B) ? S_SW_WRITE : S_LW_READ;
            end
            S_LW_READ: begin
               iord_o = 3'd1;
               if (wait_done) begin
                  state_d = S_LW_WB;
               end else begin
                  wait_d = wait_q - 2'd1;
               end
            end
            S_LW_WB: begin
               reg_write_o  = 1'b1;
               reg_dst_o    = 2'd0;
               mem_to_reg_o = 3'd1;
               state_d      = S_FETCH;
            end
            S_SW_WRITE: begin
               iord_o      = 3'd1;
               mem_write_o = 1'b1;
               state_d     = S_FETCH;
            end
            S_BRANCH: begin
               alu_src_a_o     = 1'b1;
               alu_src_b_o     = 2'd0;
               alu_op_o        = 3'd2;
               pc_write_cond_o = 1'b1;
               pc_source_o     = 2'd1;
               branch_ne_o     = opcode_i[0];
               state_d         = S_FETCH;
            end
            S_JUMP: begin
               pc_write_o  = 1'b1;
               pc_source_o = 2'd2;
               state_d     = S_FETCH;
            end
            S_JR: begin
               alu_src_a_o = 1'b1;
               alu_op_o    = 3'd0;
               pc_write_o  = 1'b1;
               pc_source_o = 2'd0;
               state_d     = S_FETCH;
            end
            S_EXC_SAVE: begin
               // PC already advanced by 4 in FETCH; subtract it back for EPC.
               alu_src_a_o = 1'b0;
               alu_src_b_o = 2'd1;
               alu_op_o    = 3'd2;
               epc_write_o = 1'b1;
               state_d     = S_EXC_READ;
            end
            S_EXC_READ: begin
               iord_o = cause_q ? 3'd4 : 3'd3;
               if (wait_done) begin
                  state_d = S_EXC_LOAD;
               end else begin
                  wait_d = wait_q - 2'd1;
               end
            end
            S_EXC_LOAD: begin
               pc_write_o  = 1'b1;
               pc_source_o = 2'd3;
               state_d     = S_FETCH;
            end
            default: state_d = S_FETCH;
         endcase
      end
   end

   // zero_i is consumed by the datapath's branch gating, not by the FSM.
   logic unused_zero;
   assign unused_zero = zero_i;

endmodule
